// File: rtl/mod_count_seq_pkg.sv
// Shared types and constants for the modulo-N run sequencer.
// State encoding is fixed so downstream debug logic can decode it directly.
package mod_count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MIN_MODULUS = 2;

endpackage

// File: rtl/mod_n_counter.sv
// Synchronous modulo-N counter with a registered one-cycle wrap pulse.
// clr wins over en; all flops share clk, so there is no ripple clocking.
module mod_n_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_top;

  assign at_top = (count_q == n - 1'b1);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (at_top) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: rtl/mod_count_sequencer.sv
// Run controller for a modulo-N counter: latches N and a wrap budget R on start,
// steps the counter until the budget is spent or stop is seen; all outputs registered.
module mod_count_sequencer
  import mod_count_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int RW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] modulus,
  input  logic [RW-1:0]    wraps,
  input  logic             pause,
  input  logic             stop,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             done,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [RW-1:0]    r_q, r_d;
  logic [RW-1:0]    wcnt_q, wcnt_d;
  logic [RW-1:0]    wcnt_inc;
  logic             err_q, err_d;
  logic             cnt_clr, cnt_en;
  logic             at_top;

  assign at_top   = (count == n_q - 1'b1);
  assign wcnt_inc = wcnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    r_d     = r_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (start) begin
          if (modulus >= WIDTH'(MIN_MODULUS)) begin
            n_d     = modulus;
            r_d     = wraps;
            wcnt_d  = '0;
            err_d   = 1'b0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          cnt_clr = 1'b1;
          state_d = DONE;
        end else if (!pause) begin
          cnt_en = 1'b1;
          if (at_top) begin
            wcnt_d = wcnt_inc;
            // A zero budget means free-run; the wrap counter just rolls over.
            if ((r_q != '0) && (wcnt_inc == r_q)) begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      r_q     <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      r_q     <= r_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  mod_n_counter #(.WIDTH(WIDTH)) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .n     (n_q),
    .count (count),
    .wrap  (wrap)
  );

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_mod_count_sequencer.sv
// Directed bench with a behavioural run model checked every cycle on the falling edge.
module tb_mod_count_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, pause, stop;
  logic [3:0] modulus;
  logic [7:0] wraps;
  logic       busy, wrap, done, err;
  logic [3:0] count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mod_count_sequencer #(.WIDTH(4), .RW(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .modulus (modulus),
    .wraps   (wraps),
    .pause   (pause),
    .stop    (stop),
    .busy    (busy),
    .count   (count),
    .wrap    (wrap),
    .done    (done),
    .err     (err)
  );

  // Behavioural model: phase 0 idle, 1 running, 2 finishing.
  int m_ph = 0, m_n = 0, m_r = 0, m_wc = 0, m_cnt = 0;
  bit m_wrap = 1'b0, m_err = 1'b0;

  always @(posedge clk) begin
    m_wrap = 1'b0;
    if (reset) begin
      m_ph = 0; m_n = 0; m_r = 0; m_wc = 0; m_cnt = 0; m_err = 1'b0;
    end else begin
      case (m_ph)
        0: if (start) begin
          if (int'(modulus) < 2) m_err = 1'b1;
          else begin
            m_n = int'(modulus); m_r = int'(wraps); m_wc = 0;
            m_cnt = 0; m_err = 1'b0; m_ph = 1;
          end
        end
        1: if (stop) begin
          m_ph = 2; m_cnt = 0;
        end else if (!pause) begin
          m_cnt = (m_cnt + 1) % m_n;
          if (m_cnt == 0) begin
            m_wrap = 1'b1;
            m_wc = (m_wc + 1) % 256;
            if (m_r != 0 && m_wc == m_r) m_ph = 2;
          end
        end
        default: m_ph = 0;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model busy",  int'(busy),  int'(m_ph == 1));
      chk("model done",  int'(done),  int'(m_ph == 2));
      chk("model count", int'(count), m_cnt);
      chk("model wrap",  int'(wrap),  int'(m_wrap));
      chk("model err",   int'(err),   int'(m_err));
      if (busy === 1'b1) chk("count below N", int'(count < 4'(m_n)), 1);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents a start for exactly one rising edge; returns at the negedge after it.
  task automatic do_start(input int n, input int r);
    modulus = 4'(n); wraps = 8'(r); start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  int exp_cnt[7] = '{0, 1, 2, 0, 1, 2, 0};
  int exp_wrp[7] = '{0, 0, 0, 1, 0, 0, 1};
  int n_done, n_wrap, max_cnt;

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
    modulus = '0; wraps = '0;
    cyc(2);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset busy", int'(busy), 0);
    chk("reset count", int'(count), 0);
    chk("reset flags", int'({wrap, done, err}), 0);

    // 1: N=3, R=2
    do_start(3, 2);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("t1 count[%0d]", i), int'(count), exp_cnt[i]);
      chk($sformatf("t1 wrap[%0d]", i), int'(wrap), exp_wrp[i]);
      if (i < 6) begin
        chk($sformatf("t1 busy[%0d]", i), int'(busy), 1);
        cyc(1);
      end
    end
    chk("t1 done", int'(done), 1);
    chk("t1 busy end", int'(busy), 0);
    cyc(1);
    chk("t1 done clear", int'(done), 0);
    chk("t1 idle", int'(busy), 0);

    // 2: rejected modulus, then N=2 R=1
    do_start(1, 4);
    chk("t2 err", int'(err), 1);
    chk("t2 busy", int'(busy), 0);
    chk("t2 count", int'(count), 0);
    cyc(2);
    chk("t2 err sticky", int'(err), 1);
    do_start(2, 1);
    chk("t2 err clear", int'(err), 0);
    chk("t2 busy run", int'(busy), 1);
    cyc(2);
    chk("t2 done", int'(done), 1);
    chk("t2 done wrap", int'(wrap), 1);
    cyc(2);

    // 3: N=5 R=0 with pause and stop
    do_start(5, 0);
    cyc(2);
    chk("t3 count before pause", int'(count), 2);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("t3 paused count", int'(count), 2);
      chk("t3 paused wrap", int'(wrap), 0);
    end
    pause = 1'b0;
    cyc(1);
    chk("t3 resume", int'(count), 3);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("t3 stop done", int'(done), 1);
    chk("t3 stop count", int'(count), 0);
    chk("t3 stop wrap", int'(wrap), 0);
    cyc(2);

    // 4: stop on the final increment of N=4 R=1
    do_start(4, 1);
    cyc(3);
    chk("t4 at top", int'(count), 3);
    stop = 1'b1;
    n_done = 0;
    cyc(1);
    stop = 1'b0;
    chk("t4 wrap", int'(wrap), 0);
    chk("t4 count", int'(count), 0);
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) n_done++;
      cyc(1);
    end
    chk("t4 one done", n_done, 1);

    // 5: N=6 R=3, inputs disturbed mid-run
    do_start(6, 3);
    n_done = 0; n_wrap = 0; max_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 4) begin modulus = 4'd2; wraps = 8'd1; start = 1'b1; end
      if (i == 5) start = 1'b0;
      if (done === 1'b1) n_done++;
      if (wrap === 1'b1) n_wrap++;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      cyc(1);
    end
    chk("t5 one done", n_done, 1);
    chk("t5 three wraps", n_wrap, 3);
    chk("t5 max count", max_cnt, 5);

    // 6: reset mid-run at count 1 of the second wrap
    do_start(3, 5);
    cyc(4);
    chk("t6 pre-reset count", int'(count), 1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("t6 reset busy", int'(busy), 0);
    chk("t6 reset count", int'(count), 0);
    chk("t6 no done", int'(done), 0);
    cyc(2);
    do_start(3, 1);
    cyc(3);
    chk("t6 rerun done", int'(done), 1);
    cyc(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
